// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg: shared condition codes, flag indices and ID/EX bundle.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       blen;
    logic       branch;
    logic [3:0] aluctl;
    logic [4:0] shctl;
    logic [3:0] byteen;
    logic [3:0] cond;
  } idex_t;

  // A bubble carries no enables and an always-true condition.
  localparam idex_t IDEX_BUBBLE = '{
    flagw:    2'b00,
    pcs:      1'b0,
    regw:     1'b0,
    memw:     1'b0,
    memtoreg: 1'b0,
    alusrc:   1'b0,
    blen:     1'b0,
    branch:   1'b0,
    aluctl:   4'h0,
    shctl:    5'h00,
    byteen:   4'h0,
    cond:     COND_AL
  };

endpackage
`default_nettype wire

// File: rtl/ex_cond_stage_cond_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cond_check: combinational ARM condition evaluation against NZCV.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  assign w_n  = Flags[FLAG_N];
  assign w_z  = Flags[FLAG_Z];
  assign w_c  = Flags[FLAG_C];
  assign w_v  = Flags[FLAG_V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    CondEx = 1'b0;
    case (cond_t'(Cond))
      EQ:      CondEx = w_z;
      NE:      CondEx = ~w_z;
      CS:      CondEx = w_c;
      CC:      CondEx = ~w_c;
      MI:      CondEx = w_n;
      PL:      CondEx = ~w_n;
      VS:      CondEx = w_v;
      VC:      CondEx = ~w_v;
      HI:      CondEx = w_c & ~w_z;
      LS:      CondEx = ~w_c | w_z;
      GE:      CondEx = w_ge;
      LT:      CondEx = ~w_ge;
      GT:      CondEx = ~w_z & w_ge;
      LE:      CondEx = w_z | ~w_ge;
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;  // 1111 is never-execute
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_cond_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_cond_stage: ID/EX register, NZCV flag register, condition gating|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ex_cond_stage
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] FlagWD,
  input  logic       PCSD,
  input  logic       RegWD,
  input  logic       MemWD,
  input  logic       MemtoRegD,
  input  logic       ALUSrcD,
  input  logic       BranchLinkEnD,
  input  logic       BranchD,
  input  logic [3:0] ALUControlD,
  input  logic [4:0] SHIFTControlD,
  input  logic [3:0] ByteEnD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlagsE,
  input  logic       StallE,
  input  logic       FlushE,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchTakenE,
  output logic       BranchLinkE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic [3:0] ALUControlE,
  output logic [4:0] SHIFTControlE,
  output logic [3:0] ByteEnE,
  output logic       CondExE,
  output logic [3:0] FlagsE
);

  idex_t      r_idex;
  idex_t      w_idex_d;
  logic [3:0] r_flags;
  logic       w_condex;
  logic [1:0] w_flag_we;

  assign w_idex_d = '{
    flagw:    FlagWD,
    pcs:      PCSD,
    regw:     RegWD,
    memw:     MemWD,
    memtoreg: MemtoRegD,
    alusrc:   ALUSrcD,
    blen:     BranchLinkEnD,
    branch:   BranchD,
    aluctl:   ALUControlD,
    shctl:    SHIFTControlD,
    byteen:   ByteEnD,
    cond:     CondD
  };

  // Flush wins over stall so a squashed instruction cannot linger in EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idex <= IDEX_BUBBLE;
    end else if (FlushE) begin
      r_idex <= IDEX_BUBBLE;
    end else if (!StallE) begin
      r_idex <= w_idex_d;
    end
  end

  cond_check u_cond_check (
    .Cond   (r_idex.cond),
    .Flags  (r_flags),
    .CondEx (w_condex)
  );

  // A stalled instruction stays in EX, so its flag write is held off.
  assign w_flag_we = r_idex.flagw & {2{w_condex & ~StallE}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_flag_we[1]) begin
        r_flags[FLAG_N:FLAG_Z] <= ALUFlagsE[FLAG_N:FLAG_Z];
      end
      if (w_flag_we[0]) begin
        r_flags[FLAG_C:FLAG_V] <= ALUFlagsE[FLAG_C:FLAG_V];
      end
    end
  end

  assign PCSrcE        = r_idex.pcs    & w_condex;
  assign RegWriteE     = r_idex.regw   & w_condex;
  assign MemWriteE     = r_idex.memw   & w_condex;
  assign BranchTakenE  = r_idex.branch & w_condex;
  assign BranchLinkE   = r_idex.blen   & w_condex;
  assign MemtoRegE     = r_idex.memtoreg;
  assign ALUSrcE       = r_idex.alusrc;
  assign ALUControlE   = r_idex.aluctl;
  assign SHIFTControlE = r_idex.shctl;
  assign ByteEnE       = r_idex.byteen;
  assign CondExE       = w_condex;
  assign FlagsE        = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_ex_cond_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ex_cond_stage: table-driven scoreboard bench for ex_cond_stage. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ex_cond_stage;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] FlagWD;
  logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchLinkEnD, BranchD;
  logic [3:0] ALUControlD;
  logic [4:0] SHIFTControlD;
  logic [3:0] ByteEnD, CondD, ALUFlagsE;
  logic       StallE, FlushE;
  logic       PCSrcE, RegWriteE, MemWriteE, BranchTakenE, BranchLinkE;
  logic       MemtoRegE, ALUSrcE, CondExE;
  logic [3:0] ALUControlE, ByteEnE, FlagsE;
  logic [4:0] SHIFTControlE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_cond_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .FlagWD        (FlagWD),
    .PCSD          (PCSD),
    .RegWD         (RegWD),
    .MemWD         (MemWD),
    .MemtoRegD     (MemtoRegD),
    .ALUSrcD       (ALUSrcD),
    .BranchLinkEnD (BranchLinkEnD),
    .BranchD       (BranchD),
    .ALUControlD   (ALUControlD),
    .SHIFTControlD (SHIFTControlD),
    .ByteEnD       (ByteEnD),
    .CondD         (CondD),
    .ALUFlagsE     (ALUFlagsE),
    .StallE        (StallE),
    .FlushE        (FlushE),
    .PCSrcE        (PCSrcE),
    .RegWriteE     (RegWriteE),
    .MemWriteE     (MemWriteE),
    .BranchTakenE  (BranchTakenE),
    .BranchLinkE   (BranchLinkE),
    .MemtoRegE     (MemtoRegE),
    .ALUSrcE       (ALUSrcE),
    .ALUControlE   (ALUControlE),
    .SHIFTControlE (SHIFTControlE),
    .ByteEnE       (ByteEnE),
    .CondExE       (CondExE),
    .FlagsE        (FlagsE)
  );

  // ctl = {pcs,regw,memw,mtr,alusrc,bl,br}; een = {c,pcsrc,regw,memw,brtaken,blink}
  typedef struct packed {
    logic [1:0] flagw;
    logic [6:0] ctl;
    logic [3:0] aluc;
    logic [4:0] shc;
    logic [3:0] be;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [5:0] een;
    logic [3:0] ef;
  } vec_t;

  typedef struct packed {
    logic [5:0]  en;
    logic [14:0] dat;
    logic [3:0]  flags;
  } exp_t;

  localparam int NVEC = 23;
  vec_t tbl [NVEC];
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    FlagWD = v.flagw;
    {PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchLinkEnD, BranchD} = v.ctl;
    ALUControlD   = v.aluc;
    SHIFTControlD = v.shc;
    ByteEnD       = v.be;
    CondD         = v.cond;
  endtask

  function automatic exp_t vexp(input vec_t v);
    exp_t e;
    e.en    = v.een;
    e.dat   = {v.ctl[3], v.ctl[2], v.aluc, v.shc, v.be};
    e.flags = v.ef;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.en    = {CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE, BranchLinkE};
    a.dat   = {MemtoRegE, ALUSrcE, ALUControlE, SHIFTControlE, ByteEnE};
    a.flags = FlagsE;
    return a;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic run_cycle(input string nm, input vec_t d, input logic [3:0] alu,
                           input logic st, input logic fl, input exp_t e);
    exp_t a, r;
    @(negedge clk);
    drive(d);
    ALUFlagsE = alu;
    StallE    = st;
    FlushE    = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    a = sample();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      r = sb.pop_front();
      chk({nm, " enables"}, 32'(a.en), 32'(r.en));
      chk({nm, " data"}, 32'(a.dat), 32'(r.dat));
      chk({nm, " flags"}, 32'(a.flags), 32'(r.flags));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t pre, s, other, tail;
    exp_t es, eb, et;

    //          flagw  ctl         aluc  shc    be    cond  alu   een        ef
    tbl[0]  = '{2'b11, 7'b0000100, 4'h2, 5'h00, 4'hF, 4'hE, 4'h4, 6'b100000, 4'h0}; // CMP Z=1
    tbl[1]  = '{2'b00, 7'b1000001, 4'h0, 5'h01, 4'h0, 4'h0, 4'h0, 6'b110010, 4'h4}; // BEQ taken
    tbl[2]  = '{2'b11, 7'b0000100, 4'h2, 5'h02, 4'hF, 4'hE, 4'h0, 6'b100000, 4'h4}; // CMP Z=0
    tbl[3]  = '{2'b00, 7'b1000001, 4'h0, 5'h03, 4'h0, 4'h0, 4'h0, 6'b000000, 4'h0}; // BEQ not taken
    tbl[4]  = '{2'b11, 7'b0110000, 4'h4, 5'h04, 4'h3, 4'hE, 4'h9, 6'b101100, 4'h0}; // sets N,V
    tbl[5]  = '{2'b11, 7'b0110000, 4'h4, 5'h05, 4'hC, 4'hB, 4'h6, 6'b000000, 4'h9}; // LT fails
    tbl[6]  = '{2'b00, 7'b0101000, 4'h8, 5'h06, 4'h1, 4'hA, 4'h0, 6'b101000, 4'h9}; // GE passes
    tbl[7]  = '{2'b11, 7'b0100000, 4'h1, 5'h07, 4'h2, 4'hF, 4'h0, 6'b000000, 4'h9}; // NV
    tbl[8]  = '{2'b11, 7'b0000100, 4'h2, 5'h08, 4'h4, 4'hE, 4'h0, 6'b100000, 4'h9}; // clear flags
    tbl[9]  = '{2'b10, 7'b0000100, 4'h2, 5'h09, 4'h8, 4'hE, 4'hF, 6'b100000, 4'h0}; // NZ-only write
    tbl[10] = '{2'b00, 7'b1100011, 4'h0, 5'h0A, 4'hF, 4'hE, 4'h0, 6'b111011, 4'hC}; // BL
    tbl[11] = '{2'b00, 7'b0000011, 4'h0, 5'h0B, 4'hF, 4'hE, 4'h0, 6'b100011, 4'hC}; // BL, PCS=0
    tbl[12] = '{2'b00, 7'b0100000, 4'h3, 5'h0C, 4'h5, 4'h8, 4'h0, 6'b000000, 4'hC}; // HI
    tbl[13] = '{2'b00, 7'b0100000, 4'h3, 5'h0D, 4'h6, 4'h9, 4'h0, 6'b101000, 4'hC}; // LS
    tbl[14] = '{2'b00, 7'b0100000, 4'h3, 5'h0E, 4'h7, 4'hC, 4'h0, 6'b000000, 4'hC}; // GT
    tbl[15] = '{2'b00, 7'b0100000, 4'h3, 5'h0F, 4'h9, 4'hD, 4'h0, 6'b101000, 4'hC}; // LE
    tbl[16] = '{2'b00, 7'b0100000, 4'h6, 5'h10, 4'hA, 4'h4, 4'h0, 6'b101000, 4'hC}; // MI
    tbl[17] = '{2'b00, 7'b0100000, 4'h6, 5'h11, 4'hB, 4'h5, 4'h0, 6'b000000, 4'hC}; // PL
    tbl[18] = '{2'b00, 7'b0100000, 4'h7, 5'h12, 4'hD, 4'h1, 4'h0, 6'b000000, 4'hC}; // NE
    tbl[19] = '{2'b00, 7'b0100000, 4'h7, 5'h13, 4'hE, 4'h2, 4'h0, 6'b000000, 4'hC}; // CS
    tbl[20] = '{2'b00, 7'b0100000, 4'h9, 5'h14, 4'h1, 4'h3, 4'h0, 6'b101000, 4'hC}; // CC
    tbl[21] = '{2'b00, 7'b0100000, 4'h9, 5'h15, 4'h2, 4'h6, 4'h0, 6'b000000, 4'hC}; // VS
    tbl[22] = '{2'b00, 7'b0100000, 4'hF, 5'h1F, 4'h4, 4'h7, 4'h0, 6'b101000, 4'hC}; // VC

    // Load a live instruction and flags, then reset asynchronously mid-cycle.
    pre = '{2'b11, 7'b0110000, 4'h5, 5'h05, 4'hF, 4'hE, 4'hF, 6'b000000, 4'h0};
    reset_n = 1'b1;
    StallE = 1'b0;
    FlushE = 1'b0;
    ALUFlagsE = 4'hF;
    drive(pre);
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset regwrite", 32'(RegWriteE), 32'd1);
    chk("pre-reset flags", 32'(FlagsE), 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset flags", 32'(FlagsE), 32'h0);
    chk("reset enables", 32'({RegWriteE, MemWriteE, PCSrcE, BranchTakenE, BranchLinkE}), 32'h0);
    chk("reset condex", 32'(CondExE), 32'd1);
    chk("reset aluctl", 32'(ALUControlE), 32'h0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_cycle($sformatf("vec%0d", i), tbl[i], (i == 0) ? 4'h0 : tbl[i-1].alu,
                1'b0, 1'b0, vexp(tbl[i]));
    end

    // Stall: the instruction in EX holds and its flag write is withheld.
    s     = '{2'b11, 7'b0100000, 4'h5, 5'h03, 4'hF, 4'hE, 4'h0, 6'b101000, 4'hC};
    other = '{2'b00, 7'b1011111, 4'hA, 5'h1E, 4'h1, 4'h0, 4'h0, 6'b000000, 4'h0};
    es = vexp(s);
    run_cycle("stall load", s, tbl[NVEC-1].alu, 1'b0, 1'b0, es);
    run_cycle("stall hold1", other, 4'h3, 1'b1, 1'b0, es);
    run_cycle("stall hold2", other, 4'h3, 1'b1, 1'b0, es);

    // Flush beats stall: bubble, flags untouched.
    eb.en = 6'b100000;
    eb.dat = 15'h0;
    eb.flags = 4'hC;
    run_cycle("stall+flush", other, 4'h3, 1'b1, 1'b1, eb);

    // Bubble in EX must not write flags; next EQ sees the preserved Z.
    tail = '{2'b11, 7'b0100000, 4'h2, 5'h01, 4'h3, 4'h0, 4'h0, 6'b101000, 4'hC};
    et = vexp(tail);
    run_cycle("after flush", tail, 4'hF, 1'b0, 1'b0, et);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
